// File: rtl/stim_sweep_gen_if.sv
// stim_sweep_gen_if: sweep control, DUT response and stimulus/status bundle.
// master: drives start/abort/mode/loop/resp, observes vec/vec_valid/idx/busy/done/wrap/sig
// slave:  the sequencer side of the same signals
interface stim_sweep_gen_if #(parameter int N = 3, parameter int M = 1);
   logic          start;
   logic          abort;
   logic [1:0]    mode;
   logic          loop;
   logic [M-1:0]  resp;
   logic [N-1:0]  vec;
   logic          vec_valid;
   logic [N-1:0]  idx;
   logic          busy;
   logic          done;
   logic          wrap;
   logic [15:0]   sig;
   modport master (output start, abort, mode, loop, resp,
                   input vec, vec_valid, idx, busy, done, wrap, sig);
   modport slave  (input start, abort, mode, loop, resp,
                   output vec, vec_valid, idx, busy, done, wrap, sig);
endinterface

// File: rtl/stim_sweep_gen.sv
// stim_sweep_gen: exhaustive binary/Gray/walking-one stimulus sweep with LFSR response signature.
// clk   rising-edge clock
// reset asynchronous active-high reset
// b     stim_sweep_gen_if.slave: start/abort/mode/loop/resp in; vec/vec_valid/idx/busy/done/wrap/sig out
module stim_sweep_gen #(
   parameter int N    = 3,
   parameter int M    = 1,
   parameter int HOLD = 1
) (
   input logic             clk,
   input logic             reset,
   stim_sweep_gen_if.slave b
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t       state_q, state_d;
   logic [N-1:0] idx_q, idx_d, vec_q, vec_d, last_idx;
   logic [7:0]   hold_q, hold_d;
   logic [15:0]  sig_q, sig_d;
   logic [1:0]   mode_q, mode_d;
   logic         loop_q, loop_d, wrap_q, wrap_d, cap;
   assign last_idx = (mode_q == 2'b10) ? N'(N - 1) : {N{1'b1}};
   assign cap      = (state_q == RUN) && (hold_q == 8'(HOLD - 1));
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      sig_d   = sig_q;
      mode_d  = mode_q;
      loop_d  = loop_q;
      wrap_d  = 1'b0;
      if (b.abort)
         state_d = IDLE;
      else if (state_q != RUN) begin
         if (b.start) begin
            state_d = RUN;
            idx_d   = '0;
            hold_d  = '0;
            sig_d   = '0;
            mode_d  = b.mode;
            loop_d  = b.loop;
         end
      end else begin
         hold_d = hold_q + 8'd1;
         if (cap) begin
            sig_d  = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]} ^ 16'(b.resp);
            hold_d = '0;
            if (idx_q != last_idx)
               idx_d = idx_q + N'(1);
            else if (loop_q) begin
               idx_d  = '0;
               wrap_d = 1'b1;
            end else
               state_d = DONE;
         end
      end
      // vec is registered from the next-state view so it is live the cycle the state/index take effect
      vec_d = (state_d != RUN) ? '0 :
              (mode_d == 2'b01) ? (idx_d ^ (idx_d >> 1)) :
              (mode_d == 2'b10) ? (N'(1) << idx_d) : idx_d;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
         hold_q  <= '0;
         sig_q   <= '0;
         mode_q  <= '0;
         loop_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         sig_q   <= sig_d;
         mode_q  <= mode_d;
         loop_q  <= loop_d;
         wrap_q  <= wrap_d;
      end
   end
   assign b.vec       = vec_q;
   assign b.vec_valid = (state_q == RUN);
   assign b.busy      = (state_q == RUN);
   assign b.done      = (state_q == DONE);
   assign b.wrap      = wrap_q;
   assign b.idx       = idx_q;
   assign b.sig       = sig_q;
endmodule

// File: tb/tb_stim_sweep_gen.sv
// tb_stim_sweep_gen: randomized and directed check of two sequencers (HOLD=1, HOLD=4) against a cycle-count model.
module tb_stim_sweep_gen;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, abort = 1'b0, loop = 1'b0, resp = 1'b0;
   logic [1:0] mode = 2'b00;
   int         total = 0, bad = 0;
   stim_sweep_gen_if #(.N(3), .M(1)) ua ();
   stim_sweep_gen_if #(.N(3), .M(1)) ub ();
   assign ua.start = start;
   assign ua.abort = abort;
   assign ua.mode  = mode;
   assign ua.loop  = loop;
   assign ua.resp  = resp;
   assign ub.start = start;
   assign ub.abort = abort;
   assign ub.mode  = mode;
   assign ub.loop  = loop;
   assign ub.resp  = resp;
   stim_sweep_gen #(.N(3), .M(1), .HOLD(1)) dut_a (.clk(clk), .reset(reset), .b(ua));
   stim_sweep_gen #(.N(3), .M(1), .HOLD(4)) dut_b (.clk(clk), .reset(reset), .b(ub));
   always #5 clk = ~clk;
   // Model: position counted in cycles since sweep start; the vector index is position / hold.
   typedef struct {
      int          st;
      int          pos;
      int          idx;
      logic [15:0] sig;
      int          mode;
      bit          loop;
      bit          wrap;
   } mdl_t;
   mdl_t ma, mb;
   function automatic mdl_t nxt(mdl_t m, int h);
      int len;
      m.wrap = 0;
      if (abort) m.st = 0;
      else if (m.st != 1) begin
         if (start) begin
            m.st = 1; m.pos = 0; m.idx = 0; m.sig = 16'h0; m.mode = int'(mode); m.loop = loop;
         end
      end else begin
         len = (m.mode == 2 ? 3 : 8) * h;
         if (m.pos % h == h - 1)
            m.sig = {m.sig[14:0], m.sig[15] ^ m.sig[13] ^ m.sig[12] ^ m.sig[10]} ^ {15'h0, resp};
         m.pos++;
         if (m.pos == len) begin
            if (m.loop) begin m.pos = 0; m.idx = 0; m.wrap = 1; end
            else m.st = 2;
         end else m.idx = m.pos / h;
      end
      return m;
   endfunction
   function automatic int ev(mdl_t m);
      if (m.st != 1) return 0;
      if (m.mode == 1) return m.idx ^ (m.idx >> 1);
      if (m.mode == 2) return 1 << m.idx;
      return m.idx;
   endfunction
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         ma = '{default: 0};
         mb = '{default: 0};
      end else begin
         ma = nxt(ma, 1);
         mb = nxt(mb, 4);
      end
   end
   task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
      end
   endtask
   always @(negedge clk) begin
      chk("a.vec", 32'(ua.vec), ev(ma));
      chk("a.vec_valid", 32'(ua.vec_valid), ma.st == 1);
      chk("a.busy", 32'(ua.busy), ma.st == 1);
      chk("a.done", 32'(ua.done), ma.st == 2);
      chk("a.wrap", 32'(ua.wrap), 32'(ma.wrap));
      chk("a.idx", 32'(ua.idx), ma.idx);
      chk("a.sig", 32'(ua.sig), 32'(ma.sig));
      chk("b.vec", 32'(ub.vec), ev(mb));
      chk("b.vec_valid", 32'(ub.vec_valid), mb.st == 1);
      chk("b.busy", 32'(ub.busy), mb.st == 1);
      chk("b.done", 32'(ub.done), mb.st == 2);
      chk("b.wrap", 32'(ub.wrap), 32'(mb.wrap));
      chk("b.idx", 32'(ub.idx), mb.idx);
      chk("b.sig", 32'(ub.sig), 32'(mb.sig));
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic go(logic [1:0] md, logic lp);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0; start = 1'b1; mode = md; loop = lp;
      step();
      start = 1'b0;
   endtask
   initial begin
      int gray [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
      #1;
      chk("reset vec", 32'(ua.vec), 0);
      chk("reset sig", 32'(ua.sig), 0);
      chk("reset done", 32'(ua.done), 0);
      step(); step();
      reset = 1'b0;
      resp = 1'b1;
      go(2'b00, 1'b0);
      chk("bin sig0", 32'(ua.sig), 0);
      for (int i = 0; i < 8; i++) begin
         chk("bin vec", 32'(ua.vec), i);
         chk("bin valid", 32'(ua.vec_valid), 1);
         if (i == 1) chk("sig1", 32'(ua.sig), 32'h0001);
         if (i == 2) chk("sig2", 32'(ua.sig), 32'h0003);
         if (i == 3) chk("sig3", 32'(ua.sig), 32'h0007);
         step();
      end
      chk("bin done", 32'(ua.done), 1);
      chk("bin busy", 32'(ua.busy), 0);
      chk("bin sig8", 32'(ua.sig), 32'h00ff);
      go(2'b01, 1'b0);
      for (int i = 0; i < 8; i++) begin
         resp = 1'($urandom_range(0, 1));
         chk("gray vec", 32'(ua.vec), gray[i]);
         step();
      end
      chk("gray done", 32'(ua.done), 1);
      go(2'b10, 1'b0);
      for (int c = 0; c < 12; c++) begin
         chk("walk vec", 32'(ub.vec), 1 << (c / 4));
         step();
      end
      chk("walk done", 32'(ub.done), 1);
      resp = 1'b0;
      go(2'b00, 1'b0);
      for (int i = 0; i < 8; i++) step();
      chk("zero sig", 32'(ua.sig), 0);
      chk("zero done", 32'(ua.done), 1);
      go(2'b00, 1'b1);
      for (int i = 0; i < 8; i++) step();
      chk("loop vec", 32'(ua.vec), 0);
      chk("loop wrap", 32'(ua.wrap), 1);
      chk("loop done", 32'(ua.done), 0);
      step();
      chk("loop wrap pulse", 32'(ua.wrap), 0);
      for (int c = 0; c < 20 && ua.idx != 3'd5; c++) step();
      chk("abort reach idx5", 32'(ua.idx), 5);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort valid", 32'(ua.vec_valid), 0);
      chk("abort idx", 32'(ua.idx), 5);
      chk("abort busy", 32'(ua.busy), 0);
      chk("abort done", 32'(ua.done), 0);
      resp = 1'b1;
      go(2'b00, 1'b0);
      step(); step(); step();
      chk("pre-reset idx", 32'(ua.idx), 3);
      #2 reset = 1'b1;
      #1;
      chk("rst vec", 32'(ua.vec), 0);
      chk("rst valid", 32'(ua.vec_valid), 0);
      chk("rst idx", 32'(ua.idx), 0);
      chk("rst busy", 32'(ua.busy), 0);
      chk("rst done", 32'(ua.done), 0);
      chk("rst wrap", 32'(ua.wrap), 0);
      chk("rst sig", 32'(ua.sig), 0);
      step();
      reset = 1'b0;
      go(2'b00, 1'b0);
      chk("restart vec", 32'(ua.vec), 0);
      chk("restart sig", 32'(ua.sig), 0);
      chk("restart valid", 32'(ua.vec_valid), 1);
      for (int c = 0; c < 1500; c++) begin
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 63) == 0);
         mode  = 2'($urandom_range(0, 3));
         loop  = ($urandom_range(0, 3) == 0);
         resp  = 1'($urandom_range(0, 1));
         step();
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/stim_sweep_gen.md
# stim_sweep_gen

Parametrised exhaustive stimulus sequencer for bench and on-board self-test of small combinational blocks. It sweeps every input combination of an N-bit DUT, holds each vector for a programmable number of clocks, and supports binary, Gray and walking-one orders plus continuous looping. On the last hold cycle of each vector it compresses the DUT response into a 16-bit LFSR signature, so a whole sweep is checked by comparing one value.

## Interface
- `N`, default 3: vector width, 1..8.
- `M`, default 1: response width, 1..16.
- `HOLD`, default 1: clocks per vector, 1..255.
- `clk` input 1: clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: begins a sweep; sampled in IDLE or DONE.
- `abort` input 1: synchronous; returns to IDLE next edge; overrides `start`.
- `mode` input 2: 00 binary, 01 Gray, 10 walking-one, 11 treated as binary; latched on accepted `start`.
- `loop` input 1: repeat the sweep forever; latched on accepted `start`.
- `resp` input M: DUT response to the current `vec`.
- `vec` output N: stimulus vector.
- `vec_valid` output 1: `vec` is a live sweep vector.
- `idx` output N: index of the current vector (0-based).
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE.
- `wrap` output 1: one-cycle pulse when a looping sweep restarts at index 0.
- `sig` output 16: response signature.

## Operation
- States: IDLE, RUN, DONE. Internal registers:
  - `hold_cnt`, 8 bits.
  - `last_idx`: 2^N−1 for binary/Gray, N−1 for walking-one.
- IDLE:
  - Outputs: `vec`=0, `vec_valid`=0, `busy`=0, `done`=0.
  - `start`=1 → RUN, with `idx`=0, `hold_cnt`=0, `sig`=0x0000, `mode` and `loop` latched.
- RUN:
  - `vec_valid`=1 and `busy`=1.
  - `vec` = `idx` (binary), `idx ^ (idx>>1)` (Gray), or `1<<idx` (walking-one).
  - `hold_cnt` increments every cycle.
- Capture cycle (RUN and `hold_cnt`==HOLD−1):
  - `sig` ← {`sig`[14:0], `sig`[15]^`sig`[13]^`sig`[12]^`sig`[10]} XOR zero-extended `resp`.
  - `hold_cnt` ← 0.
  - If `idx`≠`last_idx`: `idx` increments.
  - Else, if the latched `loop` is set: `idx` ← 0, `wrap`=1 on the next cycle, `sig` not cleared.
  - Else: → DONE.
- DONE:
  - `done`=1, `vec_valid`=0, `busy`=0, `vec`=0.
  - `idx` and `sig` hold their final values.
  - `start` → RUN (same init as from IDLE).
- Ignored inputs:
  - `start` during RUN.
  - Changes to `mode` or `loop` during RUN; they take effect only at the next accepted `start`.
- `abort` in any state → IDLE next edge. `sig` and `idx` are retained, `done`=0.
- `reset`: all registers clear immediately, independent of `clk`:
  - State IDLE.
  - `vec`, `idx`, `sig`, `hold_cnt` = 0.
  - `vec_valid`, `busy`, `done`, `wrap` = 0.
- Reset mid-sweep discards the sweep with no partial `done`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Startup: `start` sampled at edge k → first vector (`idx`=0) valid from edge k to edge k+1.
- Each vector is held exactly HOLD cycles.
- `resp` must be settled by the capture edge; the DUT path is one cycle, so HOLD=1 requires a combinational DUT.
- Sweep length:
  - 2^N×HOLD cycles for binary/Gray.
  - N×HOLD cycles for walking-one.
- End of sweep: `done` rises on the edge after the last capture.
- Loop: no idle gap; `idx`=0 follows `last_idx` directly, with `wrap` high for that first cycle.
- Simultaneous events:
  - `start`+`abort` → IDLE.
  - `reset` dominates all.

## Test plan
- Binary sweep: N=3, HOLD=1, `mode`=00, pulse `start` → `vec` 0,1,…,7 on 8 consecutive cycles; `done`=1 on cycle 9; `busy` low.
- Gray sweep: `mode`=01 → `vec` sequence 0,1,3,2,6,7,5,4; exactly one bit toggles per step.
- Walking-one with hold: `mode`=10, HOLD=4 → `vec` 001,010,100, each held 4 cycles; `done` after 12 cycles.
- Signature: `resp`=1 constant, `mode`=00 → `sig` after 1/2/3 captures = 0x0001/0x0003/0x0007. `resp`=0 for the whole sweep → `sig`=0x0000.
- Loop and abort:
  - `loop`=1 → after `vec`=7, `vec`=0 with `wrap`=1 for one cycle, `done` never asserts.
  - `abort` at `idx`=5 → IDLE next cycle, `vec_valid`=0, `idx` holds 5.
- Reset mid-sweep: assert `reset` between edges at `idx`=3 → all outputs 0 immediately. Release it, then `start` → sweep restarts at `vec`=0 with `sig`=0.
